// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : 8N1 UART receiver feeding a small first-in first-out receive queue.
// Rev     : 1.0
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_HZ   = 50000000,
    parameter int BAUDRATE = 115200,
    parameter int DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   uart_rx,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   frame_err,
    output logic                   overrun
);
    localparam int c_DIV  = CLK_HZ / BAUDRATE;
    localparam int c_HALF = c_DIV / 2;
    localparam int c_CW   = $clog2(c_DIV);
    localparam int c_AW   = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    if (c_DIV < 4) begin : g_div_check
        $error("uart_rx_fifo: CLK_HZ/BAUDRATE must be at least 4");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_rx_fifo: DEPTH must be a power of 2 in 2..16");
    end

    logic [1:0]        r_sync;
    logic [1:0]        r_live;
    logic              r_armed;
    logic              w_rx_s;
    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              w_half;
    logic              w_full;
    logic              w_cnt_clr;
    logic              w_shift;
    logic              w_push;
    logic              w_ferr;
    logic              w_pop;
    logic              w_accept;
    logic [7:0]        r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr;
    logic [c_AW-1:0]   r_rd;
    logic [c_AW:0]     r_level;

    assign w_rx_s = r_sync[1];
    assign w_half = (r_cnt == c_CW'(c_HALF - 1));
    assign w_full = (r_cnt == c_CW'(c_DIV - 1));

    // Start detection stays disarmed until the synchronizer holds a genuine
    // post-reset high, so a frame already in flight at release is ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync  <= 2'b11;
            r_live  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], uart_rx};
            r_live  <= {r_live[0], 1'b1};
            r_armed <= r_armed | (r_live[1] & w_rx_s);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_armed && !w_rx_s) w_next = S_START;
            S_START: if (w_half) w_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_full && r_bit == 3'd7) w_next = S_STOP;
            S_STOP:  if (w_full) w_next = w_rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (w_rx_s) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_clr = 1'b1;
        w_shift   = 1'b0;
        w_push    = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            S_START: w_cnt_clr = w_half;
            S_DATA: begin
                w_cnt_clr = w_full;
                w_shift   = w_full;
            end
            S_STOP: begin
                w_cnt_clr = w_full;
                w_push    = w_full & w_rx_s;
                w_ferr    = w_full & ~w_rx_s;
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_state == S_START) begin
                r_bit <= 3'd0;
            end else if (w_shift) begin
                r_bit <= r_bit + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end
        end
    end

    // A full queue still accepts a byte when the head leaves in the same cycle.
    assign w_pop    = rx_valid & rx_ready;
    assign w_accept = w_push & ((r_level < (c_AW + 1)'(DEPTH)) | w_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_level   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            frame_err <= w_ferr;
            overrun   <= w_push & ~w_accept;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_accept) begin
            r_mem[r_wr] <= r_shift;
        end
    end

    assign rx_data  = r_mem[r_rd];
    assign rx_valid = (r_level != '0);
    assign rx_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_fifo
// Brief   : Directed bench for uart_rx_fifo against a queue-based receive model.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 12500000;
    localparam int DEPTH  = 4;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int HALF   = DIV / 2;
    // Push is visible after this many rising edges, counted from the edge
    // preceding the start-bit falling edge (nominal latency plus one).
    localparam int LAT    = 2 + HALF + 9 * DIV + 1;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       uart_rx  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_level;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_rx_fifo #(
        .CLK_HZ   (CLK_HZ),
        .BAUDRATE (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_level  (rx_level),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         due;
        logic [7:0] d;
        bit         bad_stop;
    } ev_t;

    ev_t        pend[$];
    logic [7:0] mq[$];
    bit         rdy_prev  = 1'b0;
    int         ovr_seen  = 0;
    int         ferr_seen = 0;

    always @(negedge clk) begin
        bit e_fe;
        bit e_ov;
        e_fe = 1'b0;
        e_ov = 1'b0;
        if (!resetn) begin
            mq.delete();
            pend.delete();
        end else begin
            if (mq.size() > 0 && rdy_prev) void'(mq.pop_front());
            while (pend.size() > 0 && pend[0].due <= cyc) begin
                if (pend[0].due == cyc) begin
                    if (pend[0].bad_stop)        e_fe = 1'b1;
                    else if (mq.size() < DEPTH)  mq.push_back(pend[0].d);
                    else                         e_ov = 1'b1;
                end
                void'(pend.pop_front());
            end
        end
        chk("valid", rx_valid, mq.size() > 0);
        chk("level", rx_level, mq.size());
        if (!resetn)          chk("data_rst", rx_data, 0);
        else if (mq.size() > 0) chk("data", rx_data, mq[0]);
        chk("frame_err", frame_err, e_fe);
        chk("overrun", overrun, e_ov);
        rdy_prev  = rx_ready;
        ovr_seen  += overrun;
        ferr_seen += frame_err;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        wait_cyc(DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_stop);
        ev_t ev;
        ev.due      = cyc + LAT;
        ev.d        = d;
        ev.bad_stop = bad_stop;
        pend.push_back(ev);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (bad_stop) begin
            repeat (3) drive_bit(1'b0);
            uart_rx = 1'b1;
        end else begin
            drive_bit(1'b1);
        end
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        wait_cyc(DEPTH + 2);
        rx_ready = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_b [4];
        int ovr0;
        int ferr0;
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};

        wait_cyc(3);
        @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_level", rx_level, 0);
        chk("rst_data", rx_data, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        wait_cyc(4);

        // single byte, latency and head value
        send_frame(8'hA5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("a5_valid", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_level", rx_level, 1);
        @(posedge clk); #1;
        drain();

        // one-cycle glitch is rejected
        uart_rx = 1'b0;
        wait_cyc(1);
        uart_rx = 1'b1;
        wait_cyc(12);
        @(negedge clk);
        chk("glitch_valid", rx_valid, 0);
        @(posedge clk); #1;

        // five bytes into a four-entry queue
        ovr0 = ovr_seen;
        send_frame(8'h01, 1'b0);
        send_frame(8'h02, 1'b0);
        send_frame(8'h03, 1'b0);
        send_frame(8'h04, 1'b0);
        send_frame(8'h55, 1'b0);
        wait_cyc(2);
        @(negedge clk);
        chk("ovr_level", rx_level, 4);
        chk("ovr_count", ovr_seen - ovr0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pop_order", rx_data, exp_b[i]);
            @(posedge clk); #1 rx_ready = 1'b1;
            @(posedge clk); #1 rx_ready = 1'b0;
        end
        @(negedge clk);
        chk("pop_empty", rx_level, 0);
        @(posedge clk); #1;
        drain();

        // full queue with a pop coinciding with the fifth push
        ovr0 = ovr_seen;
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b0);
        send_frame(8'h44, 1'b0);
        send_frame(8'h55, 1'b0);
        rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        chk("full_pop_level", rx_level, 4);
        chk("full_pop_head", rx_data, 8'h22);
        chk("full_pop_ovr", ovr_seen - ovr0, 0);
        @(posedge clk); #1;
        drain();

        // bad stop bit held low, then a clean frame
        ferr0 = ferr_seen;
        send_frame(8'h3C, 1'b1);
        wait_cyc(8);
        @(negedge clk);
        chk("ferr_count", ferr_seen - ferr0, 1);
        chk("ferr_nopush", rx_valid, 0);
        @(posedge clk); #1;
        send_frame(8'h7E, 1'b0);
        wait_cyc(2);
        @(negedge clk);
        chk("after_break", rx_data, 8'h7E);
        @(posedge clk); #1;
        drain();

        // reset in the middle of data bit 4 with a byte already queued
        send_frame(8'h99, 1'b0);
        wait_cyc(2);
        ferr0 = ferr_seen;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        uart_rx = 1'b0;
        wait_cyc(2);
        resetn  = 1'b0;
        uart_rx = 1'b1;
        wait_cyc(2);
        @(negedge clk);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_level", rx_level, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        wait_cyc(6);
        send_frame(8'hC3, 1'b0);
        wait_cyc(2);
        @(negedge clk);
        chk("midrst_next", rx_data, 8'hC3);
        chk("midrst_ferr", ferr_seen - ferr0, 0);
        @(posedge clk); #1;
        drain();

        // line already low across reset release must not start a frame
        ferr0   = ferr_seen;
        resetn  = 1'b0;
        uart_rx = 1'b0;
        wait_cyc(2);
        resetn = 1'b1;
        wait_cyc(60);
        uart_rx = 1'b1;
        wait_cyc(10);
        @(negedge clk);
        chk("lowrel_valid", rx_valid, 0);
        chk("lowrel_ferr", ferr_seen - ferr0, 0);
        @(posedge clk); #1;
        send_frame(8'h5A, 1'b0);
        wait_cyc(2);
        @(negedge clk);
        chk("lowrel_next", rx_data, 8'h5A);
        @(posedge clk); #1;
        drain();

        wait_cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 115200: serial bit rate.
REQ-003 Parameter DEPTH, default 4: receive FIFO entries; power of 2, 2..16.
REQ-004 Derived DIV = CLK_HZ/BAUDRATE (integer) and HALF = DIV/2; elaboration SHALL fail if DIV < 4.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 uart_rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-008 rx_data  output  8  byte at FIFO head; valid only while rx_valid=1.
REQ-009 rx_valid  output  1  FIFO non-empty.
REQ-010 rx_ready  input  1  consumer accept; a pop occurs on a cycle with rx_valid=1 and rx_ready=1.
REQ-011 rx_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-014 uart_rx SHALL pass through a 2-flop synchronizer (rx_s); both flops reset to 1.
REQ-015 Receiver FSM states: IDLE, START, DATA, STOP, BREAK; a bit counter cnt counts 0..DIV-1 and a bit index runs 0..7.
REQ-016 IDLE: on rx_s==0, go to START with cnt=0.
REQ-017 START: when cnt==HALF-1, if rx_s==0 go to DATA with cnt=0 and bit index 0; otherwise treat as a glitch and return to IDLE with no output.
REQ-018 DATA: when cnt==DIV-1, shift rx_s into bit[index] (LSB first) and reset cnt; after index 7 go to STOP.
REQ-019 STOP: when cnt==DIV-1, sample rx_s.
- rx_s==1: push the byte and go to IDLE.
- rx_s==0: pulse frame_err, discard the byte, go to BREAK.
REQ-020 BREAK: remain until rx_s==1, then go to IDLE; no start detection occurs while in BREAK.
REQ-021 Push rule: a byte is accepted if rx_level < DEPTH, or if a pop occurs in the same cycle.
- Otherwise the byte is dropped, overrun pulses, and FIFO contents are unchanged.
REQ-022 The pushed byte SHALL appear with rx_valid=1 on the cycle after the stop-bit sample if the FIFO was empty, giving a total latency of 2 + HALF + 9*DIV cycles from the uart_rx falling edge (±1).
REQ-023 The FIFO is first-in first-out with wrapping read/write pointers.
- rx_data SHALL be the head entry directly from storage (no extra register stage).
- rx_data SHALL be stable while rx_valid=1 and no pop occurs.
REQ-024 Simultaneous push and pop SHALL leave rx_level unchanged.
REQ-025 A pop when empty is ignored.
REQ-026 rx_level SHALL never exceed DEPTH or wrap below 0.
REQ-027 frame_err and overrun are registered outputs and never assert in the same cycle.

Reset
REQ-028 While resetn=0, all of the following SHALL hold: FSM=IDLE; cnt, bit index and shift register =0; synchronizer =1; FIFO pointers =0.
REQ-029 Output values while resetn=0: rx_valid=0, rx_level=0, rx_data=0, frame_err=0, overrun=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame without a push or error pulse.
REQ-031 After reset release, a frame whose start edge began before release SHALL NOT be received unless the line is high for at least one cycle first.

Verification (CLK_HZ=50000000, BAUDRATE=12500000, so DIV=4, HALF=2, DEPTH=4)
REQ-032 Single byte 0xA5, rx_ready=0 -> rx_valid=1 with rx_data=0xA5 and rx_level=1, 2+2+36 (±1) cycles after the start edge; no error pulses.
REQ-033 Bytes 0x01,0x02,0x03,0x04,0x55 sent back-to-back, rx_ready=0 -> rx_level=4, one overrun pulse at the fifth stop sample; then pops with rx_ready=1 return 01,02,03,04 in order and rx_level=0.
REQ-034 FIFO full with rx_ready=1 held during the fifth stop sample -> no overrun; byte 0x55 stored; rx_level stays 4.
REQ-035 Frame 0x3C with stop bit driven 0 for 3 bit times -> one frame_err pulse, no push; the next valid frame 0x7E is received correctly.
REQ-036 Glitch: uart_rx low for 1 bit-clock (4 cycles... reduced to 1 cycle) -> FSM returns to IDLE, no push, no error.
REQ-037 resetn pulsed low during DATA bit 4 -> rx_valid=0 and rx_level=0, no error pulse; the next complete frame 0xC3 is received.
